id_ex_alu_issue: RTL

//   ID/EX pipeline register and ALU-control decoder: the producer side of the
//   ALU interface. Decodes MIPS opcode/funct into the 4-bit ALU control code,

---
 rtl/id_ex_alu_issue.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX pipeline register with an ALU-control decoder.
// This block decodes the MIPS opcode and funct fields into a 4-bit ALU code.
// It selects and extends operand B, and registers both operands with the
// EX-stage control flags. It also counts the legal instructions it issues.
//
// Pipeline control:
//   reset (active-low, asynchronous) > flush > stall > load.
//   - flush: inserts a bubble. It clears every output except issue_count,
//     and it wins over stall.
//   - stall: every output holds, including illegal and issue_count.
//   - load:  a cycle without flush or stall. When in_valid=0 it inserts a
//     bubble. When in_valid=1 the decoded instruction is captured.
//   - out_valid marks a legal instruction in EX. illegal is a flag for an
//     undecodable instruction and never occurs together with out_valid.
module id_ex_alu_issue #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    output logic [3:0]        controle,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              out_valid,
    output logic              reg_write,
    output logic [4:0]        dest_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic              is_branch,
    output logic              illegal,
    output logic [CNT_W-1:0]  issue_count
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    logic              w_legal;
    logic [3:0]        w_ctrl;
    logic [DATA_W-1:0] w_b;
    logic              w_reg_write;
    logic [4:0]        w_dest;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_branch;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_imm_zext;

    logic [3:0]        r_controle;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_out_valid;
    logic              r_reg_write;
    logic [4:0]        r_dest_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_is_branch;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_issue_count;

    assign w_imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign w_imm_zext = {{(DATA_W-16){1'b0}}, imm};

    // Decode opcode/funct into the ALU code, operand B selection and EX flags.
    always_comb begin
        w_legal     = 1'b0;
        w_ctrl      = ALU_ADD;
        w_b         = '0;
        w_reg_write = 1'b0;
        w_dest      = rt_addr;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        case (opcode)
            6'h00: begin
                w_legal     = 1'b1;
                w_b         = rt_data;
                w_reg_write = 1'b1;
                w_dest      = rd_addr;
                case (funct)
                    6'h20, 6'h21: w_ctrl = ALU_ADD;
                    6'h22, 6'h23: w_ctrl = ALU_SUB;
                    6'h24:        w_ctrl = ALU_AND;
                    6'h25:        w_ctrl = ALU_OR;
                    6'h26:        w_ctrl = ALU_XOR;
                    6'h27:        w_ctrl = ALU_NOR;
                    6'h2A:        w_ctrl = ALU_SLT;
                    default:      w_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                w_legal = 1'b1; w_ctrl = ALU_ADD; w_b = w_imm_sext; w_reg_write = 1'b1;
            end
            6'h0A: begin
                w_legal = 1'b1; w_ctrl = ALU_SLT; w_b = w_imm_sext; w_reg_write = 1'b1;
            end
            6'h0C: begin
                w_legal = 1'b1; w_ctrl = ALU_AND; w_b = w_imm_zext; w_reg_write = 1'b1;
            end
            6'h0D: begin
                w_legal = 1'b1; w_ctrl = ALU_OR; w_b = w_imm_zext; w_reg_write = 1'b1;
            end
            6'h0E: begin
                w_legal = 1'b1; w_ctrl = ALU_XOR; w_b = w_imm_zext; w_reg_write = 1'b1;
            end
            6'h23: begin
                w_legal = 1'b1; w_ctrl = ALU_ADD; w_b = w_imm_sext;
                w_mem_read = 1'b1; w_reg_write = 1'b1;
            end
            6'h2B: begin
                w_legal = 1'b1; w_ctrl = ALU_ADD; w_b = w_imm_sext; w_mem_write = 1'b1;
            end
            6'h04, 6'h05: begin
                w_legal = 1'b1; w_ctrl = ALU_SUB; w_b = rt_data; w_branch = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ID/EX register: reset > flush > stall > load (bubble, legal or illegal).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_controle    <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_out_valid   <= 1'b0;
            r_reg_write   <= 1'b0;
            r_dest_addr   <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_is_branch   <= 1'b0;
            r_illegal     <= 1'b0;
            r_issue_count <= '0;
        end else if (flush || (!stall && (!in_valid || !w_legal))) begin
            // Bubble. An illegal load is a bubble that also raises the illegal flag.
            r_controle  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_out_valid <= 1'b0;
            r_reg_write <= 1'b0;
            r_dest_addr <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_is_branch <= 1'b0;
            r_illegal   <= !flush && in_valid && !w_legal;
        end else if (!stall) begin
            r_controle    <= w_ctrl;
            r_alu_a       <= rs_data;
            r_alu_b       <= w_b;
            r_out_valid   <= 1'b1;
            r_reg_write   <= w_reg_write;
            r_dest_addr   <= w_dest;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_is_branch   <= w_branch;
            r_illegal     <= 1'b0;
            r_issue_count <= r_issue_count + 1'b1;
        end
    end

    assign controle    = r_controle;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign out_valid   = r_out_valid;
    assign reg_write   = r_reg_write;
    assign dest_addr   = r_dest_addr;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign is_branch   = r_is_branch;
    assign illegal     = r_illegal;
    assign issue_count = r_issue_count;

endmodule
